decoder_stream: RTL and testbench
=================================

Name: decoder_stream

Overview:
- Parametrised, registered binary-to-one-hot/thermometer decoder with valid/ready handshakes on both sides. It generalises the fixed 3-to-8 combinational decoder.
- Adds:
  - width generics
  - a per-transaction mode (one-hot or thermometer)
  - out-of-range error flagging
  - a 2-entry output buffer (output register + skid register) that sustains full throughput under backpressure
- Sits between a code-producing control stage and a select/enable consumer.

Parameters:
- IN_W, 3, width of input code; legal range 1..8
- OUT_W, 8, number of decoded output lines; legal range 1..2**IN_W (elaboration error otherwise)
- ERRCNT_W, 8, width of error counter (used only with the optional feature)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream presents a code
- in_ready  output  1  block can accept a code this cycle
- in_code  input  IN_W  binary code to decode
- in_mode  input  1  0 = one-hot, 1 = thermometer; sampled with in_code
- out_valid  output  1  out_y/out_err hold a valid result
- out_ready  input  1  downstream accepts result this cycle
- out_y  output  OUT_W  decoded vector
- out_err  output  1  result came from an out-of-range code
- err_count  output  ERRCNT_W  saturating error count (present only with DECODER_ERRCNT_EN)

Behaviour:
- Single clock, clk. Reset is synchronous and active-low on rst_n; all state is updated on the rising edge.
- Reset values:
  - out_valid = 0, out_y = 0, out_err = 0
  - skid register empty
  - err_count = 0
  - in_ready = 0 while rst_n = 0, then 1 from the first cycle after release
- Decode, applied at acceptance:
  - One-hot: out_y[k] = (k == code).
  - Thermometer: out_y[k] = (k <= code).
  - If code >= OUT_W, in either mode: out_y = 0 and out_err = 1; otherwise out_err = 0.
  - Comparisons are unsigned.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- in_ready = rst_n && !skid_valid. It is derived from a register only, with no combinational path from out_ready.
- Latency is 1 cycle: a code accepted at edge N appears on out_y with out_valid = 1 after edge N when the output register is free.
- Per-edge actions on input transfer:
  - If the output register is empty, or an output transfer happens the same cycle: the decoded result loads the output register.
  - Otherwise: the result loads the skid register, and in_ready drops next cycle.
- On output transfer with the skid register full:
  - The skid contents move to the output register.
  - The skid register empties; in_ready returns to 1 next cycle.
- On output transfer with the skid empty and no input transfer: out_valid -> 0. out_y/out_err keep their last values, which are don't-care for the bench.
- Simultaneous input and output transfer with the skid empty: the new result replaces the output register, out_valid stays 1, and there is no bubble.
- Simultaneous input and output transfer with the skid full: not possible, because in_ready = 0.
- Ordering: results leave in strict acceptance order; none are dropped or duplicated.
- Stability: while out_valid = 1 and out_ready = 0, out_y and out_err hold constant.
- States: EMPTY (0 entries), ONE (output register only), FULL (output + skid).
  - EMPTY -> ONE on input transfer.
  - ONE -> FULL on input transfer without output transfer.
  - ONE -> EMPTY on output transfer without input transfer.
  - FULL -> ONE on output transfer.
  - All other conditions hold the current state.
- Reset mid-operation: pending results in both registers are discarded and the block returns to EMPTY at the reset edge.
- in_code/in_mode are ignored when not accepted; X on them while in_valid = 0 has no effect.

Optional Feature:
- Macro: DECODER_ERRCNT_EN.
- Defined:
  - err_count port exists.
  - It increments by 1 on each input transfer with an out-of-range code.
  - It saturates at 2**ERRCNT_W-1 and clears only on reset.
- Undefined: port and counter are absent. out_err is still produced.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, out_y = 0 throughout. First cycle after release: in_ready = 1.
- One-hot stream (IN_W = 3, OUT_W = 6), out_ready = 1, codes 0..5 back-to-back -> out_y = 000001, 000010, ..., 100000 on consecutive cycles, one cycle after each accept. in_ready stays 1; out_err = 0.
- Thermometer: mode = 1, code 3 -> out_y = 001111; code 0 -> 000001; code 5 -> 111111.
- Out of range: codes 6 then 7, either mode -> out_y = 000000, out_err = 1 for both. With DECODER_ERRCNT_EN, err_count = 2; with ERRCNT_W = 2 and 5 errors, err_count = 3.
- Backpressure: out_ready = 0, send codes 1, 2, 3 -> 1 in output register, 2 in skid, in_ready = 0, code 3 held off. Raise out_ready -> out_y sequence 000010, 000100, 001000 with no loss or reordering.
- Reset with skid full: assert rst_n = 0 for one edge -> out_valid = 0 and in_ready = 1 after release; the pending codes never appear.

Source files
------------

// File: rtl/decoder_stream.sv
// Registered binary -> one-hot/thermometer decoder with a 2-entry (output + skid) buffer.
// Optional saturating out-of-range counter enabled by DECODER_ERRCNT_EN.
module decoder_stream #(
   parameter int IN_W     = 3,
   parameter int OUT_W    = 8,
   parameter int ERRCNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_code,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_y,
   output logic             out_err
`ifdef DECODER_ERRCNT_EN
  ,output logic [ERRCNT_W-1:0] err_count
`endif
);

   generate
      if (IN_W < 1 || IN_W > 8 || OUT_W < 1 || OUT_W > (1 << IN_W) || ERRCNT_W < 1) begin : g_bad_params
         $error("decoder_stream: illegal IN_W/OUT_W/ERRCNT_W");
      end
   endgenerate

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t           state, state_nxt;
   logic [OUT_W-1:0] out_y_q, skid_y_q, dec_y;
   logic             out_err_q, skid_err_q, dec_err;
   logic             in_xfer, out_xfer;
   logic             load_out, load_skid, skid_to_out;

   assign in_ready  = rst_n && (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_y     = out_y_q;
   assign out_err   = out_err_q;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      dec_y   = '0;
      dec_err = (int'(in_code) >= OUT_W);
      for (int k = 0; k < OUT_W; k++) begin
         if (!dec_err)
            dec_y[k] = in_mode ? (k <= int'(in_code)) : (k == int'(in_code));
      end
   end

   always_comb begin
      state_nxt   = state;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               load_out  = 1'b1;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               load_out = 1'b1;
            end else if (in_xfer) begin
               load_skid = 1'b1;
               state_nxt = FULL;
            end else if (out_xfer) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only the drain path can fire
            if (out_xfer) begin
               skid_to_out = 1'b1;
               state_nxt   = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         out_y_q    <= '0;
         out_err_q  <= 1'b0;
         skid_y_q   <= '0;
         skid_err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_out) begin
            out_y_q   <= dec_y;
            out_err_q <= dec_err;
         end else if (skid_to_out) begin
            out_y_q   <= skid_y_q;
            out_err_q <= skid_err_q;
         end
         if (load_skid) begin
            skid_y_q   <= dec_y;
            skid_err_q <= dec_err;
         end
      end
   end

`ifdef DECODER_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         err_cnt_q <= '0;
      else if (in_xfer && dec_err && (err_cnt_q != {ERRCNT_W{1'b1}}))
         err_cnt_q <= err_cnt_q + 1'b1;
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_stream.sv
// Bench for decoder_stream (IN_W=3, OUT_W=6, ERRCNT_W=2): directed steps then random traffic,
// checked against a depth-2 FIFO reference model of decoded results.
module tb_decoder_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, in_mode;
   logic [2:0] in_code;
   logic       out_valid, out_ready, out_err;
   logic [5:0] out_y;
`ifdef DECODER_ERRCNT_EN
   logic [1:0] err_count;
`endif

   int         checks = 0;
   int         errors = 0;
   logic [6:0] q[$];          // {err, y} for results held by the DUT, oldest first
   logic [1:0] ecnt = '0;
   bit         accepted;

   decoder_stream #(.IN_W(3), .OUT_W(6), .ERRCNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err)
`ifdef DECODER_ERRCNT_EN
     ,.err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] ref_dec(input int code, input bit md);
      if (code >= 6) return 6'd0;
      if (md) return 6'((1 << (code + 1)) - 1);
      return 6'(1 << code);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive, check registered outputs, clock, advance the model.
   task automatic cyc(input bit v, input logic [2:0] code, input bit md, input bit ordy);
      bit ix, ox;
      in_valid  = v;
      in_code   = v ? code : 3'bxxx;
      in_mode   = v ? md : 1'bx;
      out_ready = ordy;
      #1;
      chk("in_ready", 32'(in_ready), 32'(rst_n && q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk("out_y", 32'(out_y), 32'(q[0][5:0]));
         chk("out_err", 32'(out_err), 32'(q[0][6]));
      end else if (!rst_n) begin
         chk("rst_out_y", 32'(out_y), 32'd0);
         chk("rst_out_err", 32'(out_err), 32'd0);
      end
`ifdef DECODER_ERRCNT_EN
      chk("err_count", 32'(err_count), 32'(ecnt));
`endif
      ix = rst_n && v && (q.size() < 2);
      ox = rst_n && (q.size() > 0) && ordy;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         ecnt = '0;
      end else begin
         if (ox) void'(q.pop_front());
         if (ix) begin
            q.push_back({code >= 3'd6, ref_dec(int'(code), md)});
            if (code >= 3'd6 && ecnt != 2'd3) ecnt++;
         end
      end
      accepted = ix;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; in_code = 3'd0; in_mode = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // reset held with in_valid high
      repeat (3) cyc(1, 3'd2, 0, 1);
      rst_n = 1'b1;

      // one-hot stream, full rate
      for (int c = 0; c < 6; c++) cyc(1, 3'(c), 0, 1);
      // thermometer
      cyc(1, 3'd3, 1, 1);
      cyc(1, 3'd0, 1, 1);
      cyc(1, 3'd5, 1, 1);
      // out of range, both modes
      cyc(1, 3'd6, 0, 1);
      cyc(1, 3'd7, 1, 1);
      cyc(0, 3'd0, 0, 1);
      cyc(0, 3'd0, 0, 1);
      // more errors to reach counter saturation
      cyc(1, 3'd7, 0, 1);
      cyc(1, 3'd6, 1, 1);
      cyc(1, 3'd7, 1, 1);
      cyc(0, 3'd0, 0, 1);
      cyc(0, 3'd0, 0, 1);

      // backpressure: 1 -> output reg, 2 -> skid, 3 held off
      cyc(1, 3'd1, 0, 0);
      cyc(1, 3'd2, 0, 0);
      cyc(1, 3'd3, 0, 0);
      cyc(1, 3'd3, 0, 0);
      accepted = 0;
      for (int i = 0; i < 10 && !accepted; i++) cyc(1, 3'd3, 0, 1);
      chk("hold_accept", 32'(accepted), 32'd1);
      repeat (3) cyc(0, 3'd0, 0, 1);

      // reset while full: pending codes must vanish
      cyc(1, 3'd4, 0, 0);
      cyc(1, 3'd5, 0, 0);
      rst_n = 1'b0;
      cyc(0, 3'd0, 0, 0);
      rst_n = 1'b1;
      repeat (3) cyc(0, 3'd0, 0, 1);

      // random traffic
      for (int i = 0; i < 400; i++)
         cyc(bit'($urandom_range(0, 1)), 3'($urandom), bit'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0);
      repeat (4) cyc(0, 3'd0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
